trackball_quad_gen: RTL and testbench

//  Converts relative pointer deltas (PS/2 mouse packets from hps_io) into per-axis trackball

---
 rtl/trackball_quad_gen_pkg.sv | 56 +++++
 rtl/trackball_quad_gen_if.sv | 32 +++
 rtl/trackball_quad_gen_axis.sv | 85 ++++++++
 rtl/trackball_quad_gen.sv | 86 ++++++++
 tb/tb_trackball_quad_gen.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trackball_quad_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trackball_quad_gen_pkg                                                     |
// | Shared types, accumulator limits and saturating update for the trackball.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package trackball_quad_gen_pkg;

   typedef enum logic {
      TB_DIRCLK = 1'b0,
      TB_QUAD   = 1'b1
   } mode_e;

   // Wide enough for any accumulator up to 32 bits plus delta and step headroom.
   localparam int SAT_W         = 34;
   localparam int ACC_W_DEFAULT = 12;

   typedef logic signed [SAT_W-1:0] wide_t;

   typedef struct packed {
      wide_t value;
      logic  clamped;
   } sat_t;

   function automatic wide_t acc_limit(input int acc_w);
      wide_t one;
      one = wide_t'(1);
      return (one <<< (acc_w - 1)) - one;
   endfunction

   localparam wide_t ACC_MAX = acc_limit(ACC_W_DEFAULT);
   localparam wide_t ACC_MIN = -ACC_MAX;

   function automatic sat_t sat_add(input wide_t acc, input wide_t d,
                                    input logic signed [1:0] s, input int acc_w);
      wide_t lim;
      wide_t s_ext;
      wide_t sum;
      sat_t  r;
      lim       = acc_limit(acc_w);
      s_ext     = {{(SAT_W-2){s[1]}}, s};
      sum       = acc + d - s_ext;
      r.value   = sum;
      r.clamped = 1'b0;
      if (sum > lim) begin
         r.value   = lim;
         r.clamped = 1'b1;
      end else if (sum < -lim) begin
         r.value   = -lim;
         r.clamped = 1'b1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trackball_quad_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trackball_quad_gen_if                                                      |
// | Packet inputs, control and encoder outputs of the trackball generator.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface trackball_quad_gen_if #(
   parameter int AXES    = 2,
   parameter int DELTA_W = 9,
   parameter int SENS_W  = 3
);
   logic                    mouse_strobe;
   logic [AXES*DELTA_W-1:0] delta_i;
   logic [AXES-1:0]         invert_i;
   logic [SENS_W-1:0]       sense_i;
   logic                    enable_i;
   logic [AXES-1:0]         out_a;
   logic [AXES-1:0]         out_b;
   logic                    busy_o;
   logic                    overflow_o;

   modport master (
      output mouse_strobe, delta_i, invert_i, sense_i, enable_i,
      input  out_a, out_b, busy_o, overflow_o
   );

   modport slave (
      input  mouse_strobe, delta_i, invert_i, sense_i, enable_i,
      output out_a, out_b, busy_o, overflow_o
   );
endinterface
`default_nettype wire

// File: rtl/trackball_quad_gen_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trackball_quad_gen_axis                                                    |
// | One axis: saturating accumulator, unit stepping and encoder output regs.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trackball_quad_gen_axis
   import trackball_quad_gen_pkg::*;
#(
   parameter int    DELTA_W  = 9,
   parameter int    ACC_W    = 12,
   parameter mode_e OUT_MODE = TB_DIRCLK
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               event_i,
   input  logic               tick_i,
   input  logic [DELTA_W-1:0] delta_i,
   input  logic               invert_i,
   output logic               out_a,
   output logic               out_b,
   output logic               acc_nz_d_o,
   output logic               clamp_o
);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [1:0]              phase_q, phase_d;
   logic                    a_q, a_d;
   logic                    b_q, b_d;

   wide_t                   d_w;
   wide_t                   acc_w;
   logic                    step_w;
   logic                    pos_w;
   logic signed [1:0]       s_w;
   sat_t                    sum_w;

   always_comb begin
      d_w = {{(SAT_W-DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
      if (invert_i) d_w = -d_w;
      if (!event_i) d_w = '0;
      acc_w  = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
      step_w = tick_i && (acc_q != '0);
      pos_w  = ~acc_q[ACC_W-1];
      s_w    = step_w ? (pos_w ? 2'sb01 : 2'sb11) : 2'sb00;
      // Packet delta and step share one adder so a coincident pair is never lost.
      sum_w      = sat_add(acc_w, d_w, s_w, ACC_W);
      acc_d      = ACC_W'(sum_w.value);
      clamp_o    = event_i & sum_w.clamped;
      acc_nz_d_o = (acc_d != '0);

      phase_d = phase_q;
      a_d     = a_q;
      b_d     = b_q;
      if (step_w) begin
         if (OUT_MODE == TB_QUAD) begin
            phase_d = pos_w ? phase_q + 2'd1 : phase_q - 2'd1;
            a_d     = phase_d[1];
            b_d     = phase_d[1] ^ phase_d[0];
         end else begin
            a_d = ~a_q;
            b_d = pos_w;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         phase_q <= 2'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         phase_q <= phase_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign out_a = a_q;
   assign out_b = b_q;

endmodule
`default_nettype wire

// File: rtl/trackball_quad_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trackball_quad_gen                                                         |
// | Mouse packet deltas to per-axis dir/clock or quadrature trackball signals. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trackball_quad_gen
   import trackball_quad_gen_pkg::*;
#(
   parameter int AXES    = 2,
   parameter int DELTA_W = 9,
   parameter int ACC_W   = 12,
   parameter int SENS_W  = 3,
   parameter int MODE    = 0
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   trackball_quad_gen_if.slave  bus
);

   localparam mode_e OUT_MODE = (MODE == 1) ? TB_QUAD : TB_DIRCLK;

   logic              strobe_q, strobe_d;
   logic              armed_q, armed_d;
   logic [SENS_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic              event_w;
   logic              tick_w;
   logic [AXES-1:0]   a_w, b_w, nz_w, clamp_w;

   always_comb begin
      // armed_q keeps the first post-reset strobe sample from looking like a packet.
      event_w  = armed_q & (bus.mouse_strobe ^ strobe_q);
      strobe_d = bus.mouse_strobe;
      armed_d  = 1'b1;
      tick_w   = bus.enable_i && (cnt_q >= bus.sense_i);
      cnt_d    = cnt_q;
      if (bus.enable_i) cnt_d = tick_w ? '0 : cnt_q + SENS_W'(1);
      busy_d   = |nz_w;
      ovf_d    = |clamp_w;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         strobe_q <= 1'b0;
         armed_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         strobe_q <= strobe_d;
         armed_q  <= armed_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   for (genvar k = 0; k < AXES; k++) begin : g_axis
      trackball_quad_gen_axis #(
         .DELTA_W  (DELTA_W),
         .ACC_W    (ACC_W),
         .OUT_MODE (OUT_MODE)
      ) u_axis (
         .clk_sys    (clk_sys),
         .reset_n    (reset_n),
         .event_i    (event_w),
         .tick_i     (tick_w),
         .delta_i    (bus.delta_i[k*DELTA_W +: DELTA_W]),
         .invert_i   (bus.invert_i[k]),
         .out_a      (a_w[k]),
         .out_b      (b_w[k]),
         .acc_nz_d_o (nz_w[k]),
         .clamp_o    (clamp_w[k])
      );
   end

   assign bus.out_a      = a_w;
   assign bus.out_b      = b_w;
   assign bus.busy_o     = busy_q;
   assign bus.overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_trackball_quad_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trackball_quad_gen                                                      |
// | Directed bench driving a dir/clock and a quadrature instance in parallel.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_trackball_quad_gen;

   localparam int AXES    = 2;
   localparam int DELTA_W = 9;
   localparam int ACC_W   = 12;
   localparam int SENS_W  = 3;

   logic                    clk    = 1'b0;
   logic                    rst_n  = 1'b0;
   logic                    strobe = 1'b0;
   logic [AXES*DELTA_W-1:0] delta  = '0;
   logic [AXES-1:0]         inv    = '0;
   logic [SENS_W-1:0]       sense  = '0;
   logic                    en     = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   trackball_quad_gen_if #(.AXES(AXES), .DELTA_W(DELTA_W), .SENS_W(SENS_W)) bus0 ();
   trackball_quad_gen_if #(.AXES(AXES), .DELTA_W(DELTA_W), .SENS_W(SENS_W)) bus1 ();

   assign bus0.mouse_strobe = strobe;
   assign bus0.delta_i      = delta;
   assign bus0.invert_i     = inv;
   assign bus0.sense_i      = sense;
   assign bus0.enable_i     = en;
   assign bus1.mouse_strobe = strobe;
   assign bus1.delta_i      = delta;
   assign bus1.invert_i     = inv;
   assign bus1.sense_i      = sense;
   assign bus1.enable_i     = en;

   trackball_quad_gen #(.AXES(AXES), .DELTA_W(DELTA_W), .ACC_W(ACC_W),
                        .SENS_W(SENS_W), .MODE(0)) dut0 (
      .clk_sys (clk),
      .reset_n (rst_n),
      .bus     (bus0)
   );

   trackball_quad_gen #(.AXES(AXES), .DELTA_W(DELTA_W), .ACC_W(ACC_W),
                        .SENS_W(SENS_W), .MODE(1)) dut1 (
      .clk_sys (clk),
      .reset_n (rst_n),
      .bus     (bus1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ax, input int val);
      delta = '0;
      delta[ax*DELTA_W +: DELTA_W] = DELTA_W'(val);
      strobe = ~strobe;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((bus0.busy_o || bus1.busy_o) && n < 5000) begin
         step_clk();
         n++;
      end
      check(tag, (n >= 5000) ? 32'd1 : 32'd0, 32'd0);
   endtask

   // Runs mode-0 axis 0 until idle; counts out_a toggles and those with out_b low.
   task automatic drain_axis0(input string tag, output int tog, output int negs, output int ovfs);
      logic prev;
      int   n;
      prev = bus0.out_a[0];
      tog  = 0;
      negs = 0;
      ovfs = 0;
      n    = 0;
      while (bus0.busy_o && n < 3000) begin
         step_clk();
         n++;
         if (bus0.out_a[0] != prev) begin
            tog++;
            if (!bus0.out_b[0]) negs++;
         end
         if (bus0.overflow_o) ovfs++;
         prev = bus0.out_a[0];
      end
      step_clk();
      if (bus0.out_a[0] != prev) tog++;
      check(tag, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
   endtask

   initial begin
      logic prev;
      int   tog, negs, ovfs, first, last;
      int   tidx [3];
      logic b1, b5, b6;
      logic [1:0] ab_up [5];
      logic [1:0] ab_dn [5];
      ab_up[0] = 2'b00; ab_up[1] = 2'b01; ab_up[2] = 2'b11; ab_up[3] = 2'b10; ab_up[4] = 2'b00;
      ab_dn[0] = 2'b00; ab_dn[1] = 2'b10; ab_dn[2] = 2'b11; ab_dn[3] = 2'b01; ab_dn[4] = 2'b00;

      // Reset state
      repeat (3) step_clk();
      check("rst_out_a",  32'(bus0.out_a), 32'd0);
      check("rst_out_b",  32'(bus0.out_b), 32'd0);
      check("rst_busy",   32'(bus0.busy_o), 32'd0);
      check("rst_ovf",    32'(bus0.overflow_o), 32'd0);
      check("rst_q_ab",   32'({bus1.out_a, bus1.out_b}), 32'd0);
      rst_n = 1'b1;
      sense = '0;
      en    = 1'b1;
      repeat (3) step_clk();
      check("arm_no_evt", 32'(bus0.busy_o), 32'd0);

      // 1: +5 with sense 0 gives five back-to-back steps
      prev = bus0.out_a[0];
      tog = 0; first = 0; last = 0; b1 = 0; b5 = 0; b6 = 1;
      send(0, 5);
      for (int i = 1; i <= 10; i++) begin
         step_clk();
         if (bus0.out_a[0] != prev) begin
            tog++;
            if (first == 0) first = i;
            last = i;
         end
         prev = bus0.out_a[0];
         if (i == 1) b1 = bus0.busy_o;
         if (i == 5) b5 = bus0.busy_o;
         if (i == 6) b6 = bus0.busy_o;
      end
      check("t1_toggles", 32'(tog), 32'd5);
      check("t1_first",   32'(first), 32'd2);
      check("t1_last",    32'(last), 32'd6);
      check("t1_dir",     32'(bus0.out_b[0]), 32'd1);
      check("t1_busy_c1", 32'(b1), 32'd1);
      check("t1_busy_c5", 32'(b5), 32'd1);
      check("t1_busy_c6", 32'(b6), 32'd0);

      // 2: sense 3 spaces steps four cycles apart; invert flips direction
      sense = 3'd3;
      for (int pass = 0; pass < 2; pass++) begin
         inv = (pass == 0) ? 2'b10 : 2'b00;
         prev = bus1.out_a[1];
         prev = bus0.out_a[1];
         tog = 0;
         tidx[0] = 0; tidx[1] = 0; tidx[2] = 0;
         send(1, -3);
         for (int i = 1; i <= 20; i++) begin
            step_clk();
            if (bus0.out_a[1] != prev) begin
               if (tog < 3) tidx[tog] = i;
               tog++;
            end
            prev = bus0.out_a[1];
         end
         check(pass == 0 ? "t2_inv_toggles" : "t2_toggles", 32'(tog), 32'd3);
         check(pass == 0 ? "t2_inv_gap1" : "t2_gap1", 32'(tidx[1] - tidx[0]), 32'd4);
         check(pass == 0 ? "t2_inv_gap2" : "t2_gap2", 32'(tidx[2] - tidx[1]), 32'd4);
         check(pass == 0 ? "t2_inv_dir" : "t2_dir", 32'(bus0.out_b[1]), pass == 0 ? 32'd1 : 32'd0);
      end
      inv = '0;
      wait_idle("t2_idle_timeout");

      // 3: quadrature Gray sequence forward then back, from a clean phase
      rst_n = 1'b0;
      step_clk();
      rst_n = 1'b1;
      repeat (2) step_clk();
      sense = '0;
      send(0, 4);
      for (int i = 0; i < 5; i++) begin
         step_clk();
         check("t3_fwd_ab", 32'({bus1.out_a[0], bus1.out_b[0]}), 32'(ab_up[i]));
      end
      wait_idle("t3_idle_timeout");
      send(0, -4);
      for (int i = 0; i < 5; i++) begin
         step_clk();
         check("t3_rev_ab", 32'({bus1.out_a[0], bus1.out_b[0]}), 32'(ab_dn[i]));
      end
      wait_idle("t3_idle_timeout2");

      // 4: saturation at +2047 with stepping paused, then drained
      en = 1'b0;
      ovfs = 0;
      for (int k = 1; k <= 20; k++) begin
         send(0, 255);
         step_clk();
         if (bus0.overflow_o) ovfs++;
         if (k == 8) check("t4_no_ovf_p8", 32'(bus0.overflow_o), 32'd0);
         if (k == 9) check("t4_ovf_p9", 32'(bus0.overflow_o), 32'd1);
         step_clk();
         if (k == 9) check("t4_ovf_pulse", 32'(bus0.overflow_o), 32'd0);
      end
      check("t4_ovf_count", 32'(ovfs), 32'd12);
      check("t4_busy", 32'(bus0.busy_o), 32'd1);
      en = 1'b1;
      drain_axis0("t4_drain_timeout", tog, negs, ovfs);
      check("t4_steps", 32'(tog), 32'd2047);
      check("t4_neg_steps", 32'(negs), 32'd0);
      check("t4_ovf_drain", 32'(ovfs), 32'd0);
      wait_idle("t4_idle_timeout");

      // 5: paused accumulation of +10 and -4 nets six positive steps
      en = 1'b0;
      send(0, 10);
      repeat (2) step_clk();
      send(0, -4);
      repeat (2) step_clk();
      prev = bus0.out_a[0];
      tog = 0;
      for (int i = 0; i < 10; i++) begin
         step_clk();
         if (bus0.out_a[0] != prev) tog++;
         prev = bus0.out_a[0];
      end
      check("t5_frozen", 32'(tog), 32'd0);
      check("t5_busy", 32'(bus0.busy_o), 32'd1);
      en = 1'b1;
      drain_axis0("t5_drain_timeout", tog, negs, ovfs);
      check("t5_steps", 32'(tog), 32'd6);
      check("t5_dir", 32'(bus0.out_b[0]), 32'd1);
      wait_idle("t5_idle_timeout");

      // 6: asynchronous reset mid-stream, strobe held high across release
      en = 1'b0;
      send(0, 100);
      repeat (2) step_clk();
      check("t6_busy_pre", 32'(bus0.busy_o), 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_async_ab0", 32'({bus0.out_a, bus0.out_b}), 32'd0);
      check("t6_async_ab1", 32'({bus1.out_a, bus1.out_b}), 32'd0);
      check("t6_async_busy", 32'(bus0.busy_o), 32'd0);
      strobe = 1'b1;
      en     = 1'b1;
      repeat (2) step_clk();
      rst_n = 1'b1;
      repeat (5) step_clk();
      check("t6_no_spurious", 32'(bus0.busy_o), 32'd0);
      check("t6_outs_idle", 32'(bus0.out_a), 32'd0);
      prev = bus0.out_a[0];
      tog = 0;
      send(0, 2);
      step_clk();
      check("t6_evt_busy", 32'(bus0.busy_o), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step_clk();
         if (bus0.out_a[0] != prev) tog++;
         prev = bus0.out_a[0];
      end
      check("t6_steps", 32'(tog), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
